// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the register file write port, with
// youngest-first bypass lookup on two read addresses.
module regfile_writeback_queue #(
  parameter int DATA_WIDTH = 31,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [ADDR_WIDTH:0]          in_reg,
  input  logic [DATA_WIDTH:0]          in_data,
  output logic                         in_ready,
  input  logic                         wr_stall,
  output logic                         wr_enable,
  output logic [ADDR_WIDTH:0]          wr_reg,
  output logic [DATA_WIDTH:0]          wr_data,
  input  logic [ADDR_WIDTH:0]          rd_a_addr,
  input  logic [ADDR_WIDTH:0]          rd_b_addr,
  output logic                         byp_a_hit,
  output logic [DATA_WIDTH:0]          byp_a_data,
  output logic                         byp_b_hit,
  output logic [DATA_WIDTH:0]          byp_b_data,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH:0] q_reg  [DEPTH];
  logic [DATA_WIDTH:0] q_data [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                push;
  logic                pop;

  // Full is judged from count alone, so a same-cycle pop never frees a slot.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready & ~rst;
  assign pop      = (count != '0) & ~wr_stall;

  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= in_reg;
      q_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_enable <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        wr_enable <= 1'b1;
        wr_reg    <= q_reg[rd_ptr];
        wr_data   <= q_data[rd_ptr];
      end else begin
        wr_enable <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to newest so the last match, i.e. the youngest, wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    byp_a_hit  = 1'b0;
    byp_a_data = '0;
    byp_b_hit  = 1'b0;
    byp_b_data = '0;
    if (wr_enable && (wr_reg == rd_a_addr)) begin
      byp_a_hit  = 1'b1;
      byp_a_data = wr_data;
    end
    if (wr_enable && (wr_reg == rd_b_addr)) begin
      byp_b_hit  = 1'b1;
      byp_b_data = wr_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if (q_reg[idx] == rd_a_addr) begin
          byp_a_hit  = 1'b1;
          byp_a_data = q_data[idx];
        end
        if (q_reg[idx] == rd_b_addr) begin
          byp_b_hit  = 1'b1;
          byp_b_data = q_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: reset, latency, fill/stall,
// bypass priority, wrap-around ordering and mid-drain reset.
module tb_regfile_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_reg;
  logic [31:0] in_data;
  logic        in_ready;
  logic        wr_stall;
  logic        wr_enable;
  logic [3:0]  wr_reg;
  logic [31:0] wr_data;
  logic [3:0]  rd_a_addr;
  logic [3:0]  rd_b_addr;
  logic        byp_a_hit;
  logic [31:0] byp_a_data;
  logic        byp_b_hit;
  logic [31:0] byp_b_data;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DATA_WIDTH(31), .ADDR_WIDTH(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg(in_reg), .in_data(in_data),
    .in_ready(in_ready), .wr_stall(wr_stall), .wr_enable(wr_enable), .wr_reg(wr_reg),
    .wr_data(wr_data), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .byp_a_hit(byp_a_hit), .byp_a_data(byp_a_data), .byp_b_hit(byp_b_hit),
    .byp_b_data(byp_b_data), .count(count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_reg = 4'd9; in_data = 32'hDEAD; wr_stall = 1'b0;
    rd_a_addr = 4'd9; rd_b_addr = 4'd0;
    step(); step();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (wr_enable !== 1'b0) begin n_err++; $display("FAIL reset_wr_enable got %b want 0", wr_enable); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if ({byp_a_hit, byp_b_hit} !== 2'b00) begin n_err++; $display("FAIL reset_byp got %b want 00", {byp_a_hit, byp_b_hit}); end
    n_cmp++; if ({wr_reg, wr_data} !== 36'd0) begin n_err++; $display("FAIL reset_wr_out got %h/%h want 0/0", wr_reg, wr_data); end
    rst = 1'b0; in_valid = 1'b0;
    step();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL idle_count got %0d want 0", count); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_reg = 4'd5; in_data = 32'h0000_ABCD; rd_a_addr = 4'd5;
    step();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count_n got %0d want 1", count); end
    n_cmp++; if (wr_enable !== 1'b0) begin n_err++; $display("FAIL single_no_bypass got %b want 0", wr_enable); end
    n_cmp++; if (byp_a_hit !== 1'b1 || byp_a_data !== 32'h0000_ABCD) begin n_err++; $display("FAIL single_byp_q got %b/%h want 1/0000abcd", byp_a_hit, byp_a_data); end
    step();
    n_cmp++; if ({wr_enable, wr_reg, wr_data} !== {1'b1, 4'd5, 32'h0000_ABCD}) begin n_err++; $display("FAIL single_write got %b/%0d/%h want 1/5/0000abcd", wr_enable, wr_reg, wr_data); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count_n1 got %0d want 0", count); end
    step();
    n_cmp++; if (wr_enable !== 1'b0) begin n_err++; $display("FAIL single_one_cycle got %b want 0", wr_enable); end
    n_cmp++; if ({wr_reg, wr_data} !== {4'd5, 32'h0000_ABCD}) begin n_err++; $display("FAIL single_hold got %0d/%h want 5/0000abcd", wr_reg, wr_data); end
  endtask

  task automatic test_fill_stall();
    wr_stall = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_reg = 4'(i); in_data = 32'(i * 32'h11);
      step();
    end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
    in_reg = 4'd9; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_fifth got %0d want 4", count); end
    n_cmp++; if (wr_enable !== 1'b0) begin n_err++; $display("FAIL fill_stalled got %b want 0", wr_enable); end
    wr_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if ({wr_enable, wr_reg, wr_data} !== {1'b1, 4'(i), 32'(i * 32'h11)}) begin
        n_err++; $display("FAIL drain_%0d got %b/%0d/%h want 1/%0d/%h", i, wr_enable, wr_reg, wr_data, i, i * 32'h11);
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready_%0d got %b want 1", i, in_ready); end
    end
    step();
    n_cmp++; if (wr_enable !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL drain_end got %b/%0d want 0/0", wr_enable, count); end
  endtask

  task automatic test_bypass();
    wr_stall = 1'b1; in_valid = 1'b1;
    in_reg = 4'd7; in_data = 32'h100; step();
    in_reg = 4'd7; in_data = 32'h200; step();
    in_valid = 1'b0;
    rd_a_addr = 4'd7; rd_b_addr = 4'd3; #1;
    n_cmp++; if (byp_a_hit !== 1'b1 || byp_a_data !== 32'h200) begin n_err++; $display("FAIL byp_youngest got %b/%h want 1/200", byp_a_hit, byp_a_data); end
    n_cmp++; if (byp_b_hit !== 1'b0 || byp_b_data !== 32'h0) begin n_err++; $display("FAIL byp_miss got %b/%h want 0/0", byp_b_hit, byp_b_data); end
    rd_b_addr = 4'd7; #1;
    n_cmp++; if (byp_b_hit !== 1'b1 || byp_b_data !== 32'h200) begin n_err++; $display("FAIL byp_both got %b/%h want 1/200", byp_b_hit, byp_b_data); end
    rd_b_addr = 4'd3;
    wr_stall = 1'b0;
    step();
    n_cmp++; if (byp_a_hit !== 1'b1 || byp_a_data !== 32'h200) begin n_err++; $display("FAIL byp_queue_over_out got %b/%h want 1/200", byp_a_hit, byp_a_data); end
    step();
    n_cmp++; if (byp_a_hit !== 1'b1 || byp_a_data !== 32'h200 || wr_enable !== 1'b1) begin n_err++; $display("FAIL byp_out_reg got %b/%h want 1/200", byp_a_hit, byp_a_data); end
    step();
    n_cmp++; if (byp_a_hit !== 1'b0 || byp_a_data !== 32'h0) begin n_err++; $display("FAIL byp_gone got %b/%h want 0/0", byp_a_hit, byp_a_data); end
  endtask

  task automatic test_wrap();
    logic [35:0] exp_q[$];
    logic [35:0] exp;
    logic        exp_en;
    int          pushed;
    wr_stall = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_reg = 4'(i + 8); in_data = 32'h1000 + 32'(i);
      exp_q.push_back({in_reg, in_data});
      step();
    end
    pushed = 2;
    for (int i = 0; i < 14; i++) begin
      if (i % 3 == 2) begin
        in_valid = 1'b0; wr_stall = 1'b1; exp_en = 1'b0;
      end else begin
        in_valid = 1'b1; wr_stall = 1'b0; exp_en = 1'b1;
        in_reg = 4'(pushed); in_data = 32'h1000 + 32'(pushed);
        pushed++;
      end
      if (in_valid) exp_q.push_back({in_reg, in_data});
      step();
      n_cmp++; if (wr_enable !== exp_en) begin n_err++; $display("FAIL wrap_en_%0d got %b want %b", i, wr_enable, exp_en); end
      if (exp_en) begin
        exp = exp_q.pop_front();
        n_cmp++; if ({wr_reg, wr_data} !== exp) begin n_err++; $display("FAIL wrap_order_%0d got %h want %h", i, {wr_reg, wr_data}, exp); end
      end
      n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL wrap_count_%0d got %0d want 2", i, count); end
    end
    in_valid = 1'b0; wr_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      exp = exp_q.pop_front();
      n_cmp++; if ({wr_enable, wr_reg, wr_data} !== {1'b1, exp}) begin n_err++; $display("FAIL wrap_tail_%0d got %b/%h want 1/%h", i, wr_enable, {wr_reg, wr_data}, exp); end
    end
    step();
    n_cmp++; if (count !== 3'd0 || wr_enable !== 1'b0) begin n_err++; $display("FAIL wrap_empty got %0d/%b want 0/0", count, wr_enable); end
  endtask

  task automatic test_reset_mid();
    wr_stall = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_reg = 4'(i + 10); in_data = 32'hA0 + 32'(i);
      step();
    end
    in_valid = 1'b0; wr_stall = 1'b0;
    step();
    n_cmp++; if (wr_enable !== 1'b1 || count !== 3'd3) begin n_err++; $display("FAIL mid_pre got %b/%0d want 1/3", wr_enable, count); end
    rst = 1'b1; rd_a_addr = 4'd11; rd_b_addr = 4'd13;
    step();
    rst = 1'b0;
    n_cmp++; if (count !== 3'd0 || wr_enable !== 1'b0) begin n_err++; $display("FAIL mid_rst got %0d/%b want 0/0", count, wr_enable); end
    n_cmp++; if ({byp_a_hit, byp_b_hit} !== 2'b00) begin n_err++; $display("FAIL mid_byp got %b want 00", {byp_a_hit, byp_b_hit}); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (wr_enable !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL mid_discard_%0d got %b/%0d want 0/0", i, wr_enable, count); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_bypass();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Producer side of the register file write port (data_In, data_InReg, enable).
- Accepts writeback requests from the execute stage over a valid/ready handshake and buffers them in a small in-order queue.
- Drains the queue one entry per cycle into the register file, honouring a stall input.
- Provides combinational bypass lookup on two read addresses so the operand path sees pending writes before they land in the register file.

Parameters:
- DATA_WIDTH, 31, MSB index of the write data (data is DATA_WIDTH+1 bits).
- ADDR_WIDTH, 3, MSB index of the register address (4-bit address, 16 registers).
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  writeback request present.
- in_reg  in  ADDR_WIDTH+1  destination register.
- in_data  in  DATA_WIDTH+1  write value.
- in_ready  out  1  queue can accept this cycle.
- wr_stall  in  1  register file cannot take a write this cycle.
- wr_enable  out  1  drives register file enable; registered.
- wr_reg  out  ADDR_WIDTH+1  drives data_InReg; registered.
- wr_data  out  DATA_WIDTH+1  drives data_In; registered.
- rd_a_addr  in  ADDR_WIDTH+1  operand A register address.
- rd_b_addr  in  ADDR_WIDTH+1  operand B register address.
- byp_a_hit  out  1  pending write to rd_a_addr exists.
- byp_a_data  out  DATA_WIDTH+1  youngest pending value for rd_a_addr.
- byp_b_hit  out  1  pending write to rd_b_addr exists.
- byp_b_data  out  DATA_WIDTH+1  youngest pending value for rd_b_addr.
- count  out  clog2(DEPTH)+1  entries currently queued.

Behaviour:
- Reset: count=0, read/write pointers=0, wr_enable=0, wr_reg=0, wr_data=0. All queued entries are discarded, including a reset asserted mid-drain. in_valid is ignored while rst is high.
- in_ready = (count < DEPTH), combinational from count only. There is no push-when-full even if a pop occurs in the same cycle.
- Push: on an edge with in_valid & in_ready, {in_reg, in_data} is written at the write pointer; the write pointer increments modulo DEPTH.
- Pop: on an edge with count>0 & !wr_stall, the head entry is loaded into wr_reg/wr_data, wr_enable is set to 1, and the read pointer increments modulo DEPTH.
  - Otherwise wr_enable is cleared to 0 on that edge.
  - wr_reg/wr_data hold their last values when wr_enable=0.
- Push and pop on the same edge: both happen, and count is unchanged.
- count updates: +1 on push only, -1 on pop only.
- Latency: a request accepted at edge N into an empty queue (with wr_stall low) gives wr_enable=1 after edge N+1, for exactly one cycle. There is no same-edge bypass from in_* to wr_*.
- Back-to-back: with a continuous supply and wr_stall=0, throughput is 1 write per cycle and count stays ≤1.
- Ordering: strict FIFO. Two writes to the same register land in arrival order.
- Bypass (combinational), searched in this order, youngest first:
  1. valid queue entries from the newest down to the head;
  2. then the output register if wr_enable=1.
  - First match sets hit=1 and data to that entry's value.
  - No match gives hit=0 and data=0.
  - Entries not yet accepted (current in_*) are not searched.
  - A and B lookups are independent; both may hit the same entry.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Full versus empty is determined by count, not pointer equality.
- wr_stall high with count=0 has no effect; wr_enable=0.

Test Plan:
- Reset then idle: assert rst 2 cycles with in_valid=1 -> count=0, wr_enable=0, in_ready=1, bypass hits 0.
- Single write: push reg 5 data 0x0000_ABCD at edge N, wr_stall=0 -> wr_enable=1, wr_reg=5, wr_data=0x0000_ABCD only in the cycle after edge N+1; count returns to 0.
- Fill and stall: wr_stall=1, push regs 1,2,3,4 with data 0x11..0x44 -> count=4, in_ready=0; a 5th push is not accepted.
  - Release wr_stall -> writes emerge 1,2,3,4 on consecutive cycles; in_ready rises after the first pop.
- Bypass youngest wins: wr_stall=1, push reg 7=0x100 then reg 7=0x200, rd_a_addr=7, rd_b_addr=3 -> byp_a_hit=1, byp_a_data=0x200, byp_b_hit=0.
  - Drain both -> byp_a_data=0x200 while the last entry sits in the output register, then hit=0.
- Simultaneous push/pop with wrap: keep count at 2 with alternate stalls for 10 cycles so the pointers wrap twice -> output order equals input order, and count never exceeds DEPTH.
- Reset mid-operation: 3 entries queued, wr_enable=1, assert rst one cycle -> next cycle count=0, wr_enable=0, bypass hits 0; discarded entries never appear on wr_*.
